tx_resp_packer: RTL and testbench

TX_RESP_PACKER -- requirements
Module: tx_resp_packer

---
 rtl/tx_resp_packer_pkg.sv | 12 +
 rtl/tx_resp_packer.sv | 126 ++++++++++++
 tb/tb_tx_resp_packer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_resp_packer_pkg.sv
// Shared types and defaults for the TX response packer.
package tx_resp_packer_pkg;

   localparam int TX_RESP_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SEND_FIRST  = 2'd1,
      SEND_SECOND = 2'd2
   } resp_state_e;

endpackage

// File: rtl/tx_resp_packer.sv
// Packs RF read data (1 byte) or ALU results (2 bytes) into TX FIFO writes,
// discarding and counting responses that arrive while one is in flight.
module tx_resp_packer
   import tx_resp_packer_pkg::*;
#(
   parameter int DATA_WIDTH = TX_RESP_DATA_WIDTH,
   parameter int LSB_FIRST  = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RF_RdData,
   input  logic                    RF_RdData_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic                    FIFO_FULL,
   output logic [DATA_WIDTH-1:0]   UART_TX_DATA,
   output logic                    UART_TX_VLD,
   output logic                    BUSY,
   output logic                    DROP,
   output logic [7:0]              DROP_CNT,
   output logic [1:0]              DBG_STATE
);

   resp_state_e               r_state;
   resp_state_e               w_next_state;
   logic [2*DATA_WIDTH-1:0]   r_data;
   logic                      r_two_byte;
   logic [DATA_WIDTH-1:0]     r_tx_data;
   logic                      r_tx_vld;
   logic                      r_drop;
   logic [7:0]                r_drop_cnt;

   logic                      w_issue;
   logic                      w_capture_alu;
   logic                      w_capture_rf;
   logic [1:0]                w_drop_n;
   logic [DATA_WIDTH-1:0]     w_tx_byte;
   logic [DATA_WIDTH-1:0]     w_lo;
   logic [DATA_WIDTH-1:0]     w_hi;
   logic [8:0]                w_cnt_sum;
   logic [7:0]                w_cnt_next;
   logic                      w_can_issue;

   assign w_lo = r_data[DATA_WIDTH-1:0];
   assign w_hi = r_data[2*DATA_WIDTH-1:DATA_WIDTH];

   // The UART_TX_VLD term forces a gap cycle so FIFO_FULL reflects the last write.
   assign w_can_issue = !FIFO_FULL && !r_tx_vld;

   always_comb begin
      w_next_state  = r_state;
      w_issue       = 1'b0;
      w_capture_alu = 1'b0;
      w_capture_rf  = 1'b0;
      w_drop_n      = 2'd0;
      w_tx_byte     = r_tx_data;
      case (r_state)
         IDLE: begin
            if (ALU_OUT_VLD) begin
               w_capture_alu = 1'b1;
               w_next_state  = SEND_FIRST;
               w_drop_n      = {1'b0, RF_RdData_VLD};
            end else if (RF_RdData_VLD) begin
               w_capture_rf = 1'b1;
               w_next_state = SEND_FIRST;
            end
         end
         SEND_FIRST: begin
            w_drop_n = {1'b0, ALU_OUT_VLD} + {1'b0, RF_RdData_VLD};
            if (w_can_issue) begin
               w_issue      = 1'b1;
               w_tx_byte    = (r_two_byte && LSB_FIRST == 0) ? w_hi : w_lo;
               w_next_state = r_two_byte ? SEND_SECOND : IDLE;
            end
         end
         SEND_SECOND: begin
            w_drop_n = {1'b0, ALU_OUT_VLD} + {1'b0, RF_RdData_VLD};
            if (w_can_issue) begin
               w_issue      = 1'b1;
               w_tx_byte    = (LSB_FIRST != 0) ? w_hi : w_lo;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign w_cnt_sum  = {1'b0, r_drop_cnt} + {7'b0, w_drop_n};
   assign w_cnt_next = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];

   always_ff @(posedge CLK) begin
      if (!RST) r_state <= IDLE;
      else      r_state <= w_next_state;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_data     <= '0;
         r_two_byte <= 1'b0;
         r_tx_data  <= '0;
         r_tx_vld   <= 1'b0;
         r_drop     <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else begin
         if (w_capture_alu) begin
            r_data     <= ALU_OUT;
            r_two_byte <= 1'b1;
         end else if (w_capture_rf) begin
            r_data     <= {{DATA_WIDTH{1'b0}}, RF_RdData};
            r_two_byte <= 1'b0;
         end
         r_tx_vld <= w_issue;
         if (w_issue) r_tx_data <= w_tx_byte;
         r_drop     <= (w_drop_n != 2'd0);
         r_drop_cnt <= w_cnt_next;
      end
   end

   assign UART_TX_DATA = r_tx_data;
   assign UART_TX_VLD  = r_tx_vld;
   assign BUSY         = (r_state != IDLE);
   assign DROP         = r_drop;
   assign DROP_CNT     = r_drop_cnt;
   assign DBG_STATE    = r_state;

endmodule

// File: tb/tb_tx_resp_packer.sv
// Bench for tx_resp_packer: two instances (low-byte-first and high-byte-first)
// share stimulus; monitors pop expected bytes from per-instance queues.
module tb_tx_resp_packer;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  rf_data;
   logic        rf_vld;
   logic [15:0] alu_out;
   logic        alu_vld;
   logic        fifo_full;

   logic [7:0]  tx_data_l, tx_data_m;
   logic        tx_vld_l, tx_vld_m;
   logic        busy_l, busy_m;
   logic        drop_l, drop_m;
   logic [7:0]  cnt_l, cnt_m;
   logic [1:0]  st_l, st_m;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q_l[$];
   logic [7:0] exp_q_m[$];
   int exp_cnt = 0;
   int exp_pulses = 0;
   int seen_l = 0;
   int seen_m = 0;

   always #5 CLK = ~CLK;

   tx_resp_packer #(.DATA_WIDTH(8), .LSB_FIRST(1)) u_dut_lsb (
      .CLK(CLK), .RST(RST), .RF_RdData(rf_data), .RF_RdData_VLD(rf_vld),
      .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_vld), .FIFO_FULL(fifo_full),
      .UART_TX_DATA(tx_data_l), .UART_TX_VLD(tx_vld_l), .BUSY(busy_l),
      .DROP(drop_l), .DROP_CNT(cnt_l), .DBG_STATE(st_l)
   );

   tx_resp_packer #(.DATA_WIDTH(8), .LSB_FIRST(0)) u_dut_msb (
      .CLK(CLK), .RST(RST), .RF_RdData(rf_data), .RF_RdData_VLD(rf_vld),
      .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_vld), .FIFO_FULL(fifo_full),
      .UART_TX_DATA(tx_data_m), .UART_TX_VLD(tx_vld_m), .BUSY(busy_m),
      .DROP(drop_m), .DROP_CNT(cnt_m), .DBG_STATE(st_m)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: every FIFO write must match the head of its queue.
   always @(negedge CLK) begin
      if (tx_vld_l) begin
         if (exp_q_l.size() == 0) begin
            total++; bad++;
            $display("FAIL lsb_unexpected_write: got 0x%0h expected no write", tx_data_l);
         end else begin
            check("lsb_write_data", {24'd0, tx_data_l}, {24'd0, exp_q_l.pop_front()});
         end
      end
      if (drop_l) seen_l++;
   end

   always @(negedge CLK) begin
      if (tx_vld_m) begin
         if (exp_q_m.size() == 0) begin
            total++; bad++;
            $display("FAIL msb_unexpected_write: got 0x%0h expected no write", tx_data_m);
         end else begin
            check("msb_write_data", {24'd0, tx_data_m}, {24'd0, exp_q_m.pop_front()});
         end
      end
      if (drop_m) seen_m++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic note_drop(input int n);
      exp_cnt = (exp_cnt + n > 255) ? 255 : exp_cnt + n;
      if (n > 0) exp_pulses++;
   endtask

   task automatic send_rf(input logic [7:0] b);
      rf_data = b;
      rf_vld  = 1'b1;
      exp_q_l.push_back(b);
      exp_q_m.push_back(b);
      tick(1);
      rf_vld = 1'b0;
   endtask

   task automatic send_alu(input logic [15:0] w, input bit with_rf, input bit both_bytes);
      alu_out = w;
      alu_vld = 1'b1;
      rf_data = 8'h77;
      rf_vld  = with_rf;
      exp_q_l.push_back(w[7:0]);
      exp_q_m.push_back(w[15:8]);
      if (both_bytes) begin
         exp_q_l.push_back(w[15:8]);
         exp_q_m.push_back(w[7:0]);
      end
      if (with_rf) note_drop(1);
      tick(1);
      alu_vld = 1'b0;
      rf_vld  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q_l.size() != 0 || exp_q_m.size() != 0 || busy_l || busy_m) && n < 200) begin
         tick(1);
         n++;
      end
      check({name, "_drain_in_time"}, {31'd0, (n < 200)}, 32'd1);
      tick(2);
   endtask

   task automatic check_drops(input string name);
      check({name, "_cnt_lsb"}, {24'd0, cnt_l}, exp_cnt);
      check({name, "_cnt_msb"}, {24'd0, cnt_m}, exp_cnt);
      check({name, "_pulses_lsb"}, seen_l, exp_pulses);
      check({name, "_pulses_msb"}, seen_m, exp_pulses);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b0; rf_data = '0; rf_vld = 1'b0; alu_out = '0; alu_vld = 1'b0; fifo_full = 1'b0;
      tick(3);
      @(negedge CLK);
      check("rst_vld", {31'd0, tx_vld_l | tx_vld_m}, 32'd0);
      check("rst_data", {16'd0, tx_data_l, tx_data_m}, 32'd0);
      check("rst_busy_drop", {30'd0, busy_l | busy_m, drop_l | drop_m}, 32'd0);
      check("rst_cnt", {16'd0, cnt_l, cnt_m}, 32'd0);
      RST = 1'b1;
      tick(2);

      // Single RF byte: write one cycle after the capture cycle, then idle.
      send_rf(8'hA5);
      @(negedge CLK);
      check("rf_busy_while_pending", {31'd0, busy_l}, 32'd1);
      check("rf_no_write_yet", {31'd0, tx_vld_l}, 32'd0);
      @(negedge CLK);
      check("rf_write_vld", {31'd0, tx_vld_l}, 32'd1);
      check("rf_busy_low", {31'd0, busy_l}, 32'd0);
      wait_drain("rf_a5");

      // ALU 0x1234: byte order per instance, one idle cycle between writes.
      send_alu(16'h1234, 1'b0, 1'b1);
      @(negedge CLK);
      check("alu_lat_c0", {30'd0, tx_vld_l, tx_vld_m}, 32'd0);
      @(negedge CLK);
      check("alu_lat_c1_vld", {30'd0, tx_vld_l, tx_vld_m}, 32'd3);
      check("alu_lat_c1_data", {16'd0, tx_data_l, tx_data_m}, 32'h3412);
      @(negedge CLK);
      check("alu_lat_c2_gap", {30'd0, tx_vld_l, tx_vld_m}, 32'd0);
      @(negedge CLK);
      check("alu_lat_c3_vld", {30'd0, tx_vld_l, tx_vld_m}, 32'd3);
      check("alu_lat_c3_data", {16'd0, tx_data_l, tx_data_m}, 32'h1234);
      wait_drain("alu_1234");

      // New response accepted in the cycle the previous write strobes.
      send_rf(8'h5A);
      tick(1);
      send_rf(8'hC7);
      wait_drain("back_to_back");
      check_drops("no_drops_yet");

      // FIFO full holds the response; no byte lost or duplicated.
      fifo_full = 1'b1;
      send_alu(16'hBEEF, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check("full_no_write", {30'd0, tx_vld_l, tx_vld_m}, 32'd0);
      end
      tick(1);
      fifo_full = 1'b0;
      wait_drain("beef_full");

      // Both valids in IDLE, then RF valid while in SEND_SECOND.
      send_alu(16'h9A3C, 1'b1, 1'b1);
      tick(1);
      rf_vld = 1'b1;
      note_drop(1);
      tick(1);
      rf_vld = 1'b0;
      wait_drain("drop_two");
      check_drops("drop_two");

      // Both valids outside IDLE: one pulse, count +2, in-flight bytes intact.
      send_alu(16'h5566, 1'b0, 1'b1);
      tick(1);
      alu_out = 16'hFFFF;
      alu_vld = 1'b1;
      rf_vld  = 1'b1;
      note_drop(2);
      tick(1);
      alu_vld = 1'b0;
      rf_vld  = 1'b0;
      wait_drain("drop_both");
      check_drops("drop_both");

      // 300 discards while held by FIFO_FULL: counter saturates.
      fifo_full = 1'b1;
      send_alu(16'hA1B2, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) begin
         rf_vld = 1'b1;
         note_drop(1);
         tick(1);
      end
      rf_vld = 1'b0;
      @(negedge CLK);
      check("sat_cnt_lsb", {24'd0, cnt_l}, 32'd255);
      check("sat_cnt_msb", {24'd0, cnt_m}, 32'd255);
      tick(1);
      fifo_full = 1'b0;
      wait_drain("saturate");
      check_drops("saturate");

      // Reset in SEND_SECOND: second byte abandoned; valid during reset ignored.
      send_alu(16'hC3D2, 1'b0, 1'b0);
      tick(1);
      RST     = 1'b0;
      rf_data = 8'h99;
      rf_vld  = 1'b1;
      tick(1);
      rf_vld  = 1'b0;
      @(negedge CLK);
      check("midrst_vld", {30'd0, tx_vld_l, tx_vld_m}, 32'd0);
      check("midrst_data", {16'd0, tx_data_l, tx_data_m}, 32'd0);
      check("midrst_busy_drop", {28'd0, busy_l, busy_m, drop_l, drop_m}, 32'd0);
      check("midrst_cnt", {16'd0, cnt_l, cnt_m}, 32'd0);
      RST = 1'b1;
      exp_cnt = 0;
      tick(8);
      check("postrst_idle", {30'd0, busy_l, busy_m}, 32'd0);
      check("postrst_cnt", {16'd0, cnt_l, cnt_m}, 32'd0);

      send_alu(16'h0F1E, 1'b0, 1'b1);
      wait_drain("after_reset");
      check_drops("final");
      check("queues_empty", exp_q_l.size() + exp_q_m.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
